// File: rtl/async_fifo_reader.sv
// Read-side FIFO consumer: 2-entry skid buffer, valid/ready stream framed into PKT_LEN-beat packets.
// Pop-to-m_valid latency 1 cycle; stops popping at occ=2; FIFO_READER_STATS_EN adds stall/starve counters.
module async_fifo_reader #(
  parameter int DW      = 16,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_rempty,
  input  logic [DW-1:0]    fifo_rdata,
  output logic             fifo_rd,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] words_out
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      starve_cnt
`endif
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic {STARTUP, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic [DW-1:0]    buf0_q, buf0_d;
  logic [DW-1:0]    buf1_q, buf1_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             push;
  logic             pop;

  // buf0 is always the head; buf1 only holds a word while occ=2
  always_comb begin
    push    = (state_q == RUN) & enable & ~flush & ~fifo_rempty & (occ_q != 2'd2);
    pop     = (occ_q != 2'd0) & m_ready;
    state_d = RUN;
    occ_d   = occ_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    beat_d  = beat_q;
    words_d = words_q;

    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_rdata;
        else               buf1_d = fifo_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: buf0_d = fifo_rdata;
      default: ;
    endcase

    if (pop) begin
      beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
      words_d = words_q + CNT_W'(1);
    end

    // a beat taken during flush still counts in words_out, but framing restarts
    if (flush) begin
      occ_d  = 2'd0;
      beat_d = '0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= STARTUP;
      occ_q   <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      beat_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      beat_q  <= beat_d;
      words_q <= words_d;
    end
  end

  assign fifo_rd   = push;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q;
  assign m_last    = m_valid & (beat_q == LAST_BEAT);
  assign words_out = words_q;

`ifdef FIFO_READER_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] starve_q, starve_d;

  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (m_valid && !m_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
    if (state_q == RUN && enable && occ_q == 2'd0 && fifo_rempty && starve_q != 16'hFFFF)
      starve_d = starve_q + 16'd1;
    if (flush) begin
      stall_d  = 16'd0;
      starve_d = 16'd0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_q  <= 16'd0;
      starve_q <= 16'd0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed bench for async_fifo_reader: queue-based FIFO model, hand-computed beat/framing expectations.
module tb_async_fifo_reader;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b1;
  logic        enable, flush, fifo_rempty, m_ready;
  logic [15:0] fifo_rdata;
  logic        fifo_rd, m_valid, m_last;
  logic [15:0] m_data, words_out;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] stall_cnt, starve_cnt;
`endif

  async_fifo_reader #(.DW(16), .PKT_LEN(8), .CNT_W(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .flush(flush),
    .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .words_out(words_out)
`ifdef FIFO_READER_STATS_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          model_occ = 0;
  int          cyc;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_dat[$];
  logic        got_last[$];
  logic        s_rd, s_vld, s_last, s_rdy, s_flush;
  logic [15:0] s_dat, s_wo;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dat;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] got_at(input int i);
    return (i < got_dat.size()) ? got_dat[i] : 16'hxxxx;
  endfunction

  function automatic logic last_at(input int i);
    return (i < got_last.size()) ? got_last[i] : 1'bx;
  endfunction

  task automatic refresh_fifo();
    fifo_rempty = (fifo_q.size() == 0);
    fifo_rdata  = fifo_rempty ? 16'h0 : fifo_q[0];
  endtask

  // one clock: sample at negedge, check invariants, then pop the FIFO model after the edge
  task automatic step();
    @(negedge rclk);
    s_rd = fifo_rd; s_vld = m_valid; s_dat = m_data; s_last = m_last;
    s_rdy = m_ready; s_flush = flush; s_wo = words_out;
    if (!rrst_n) begin
      model_occ  = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (fifo_rempty)     chk("rd_when_empty", s_rd, 0);
      if (s_flush)         chk("rd_in_flush", s_rd, 0);
      if (model_occ == 2)  chk("rd_at_occ2", s_rd, 0);
      chk("vld_vs_occ", s_vld, model_occ != 0);
      if (prev_stall) begin
        chk("stall_dat", s_dat, prev_dat);
        chk("stall_last", s_last, prev_last);
      end
      if (s_vld && s_rdy) begin
        n_acc++;
        got_dat.push_back(s_dat);
        got_last.push_back(s_last);
        if (exp_q.size() > 0) chk("order", s_dat, exp_q.pop_front());
      end
      prev_stall = s_vld && !s_rdy && !s_flush;
      prev_dat   = s_dat;
      prev_last  = s_last;
      if (s_rd) exp_q.push_back(fifo_rdata);
      if (s_flush) exp_q.delete();
      model_occ = s_flush ? 0 : model_occ + int'(s_rd) - int'(s_vld && s_rdy);
      chk("occ_bound", model_occ <= 2, 1);
    end
    @(posedge rclk);
    #1;
    if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    enable  = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    refresh_fifo();
    step();
    step();
    got_dat.delete();
    got_last.delete();
    n_acc = 0;
  endtask

  task automatic load_words(input int n);
    for (int i = 1; i <= n; i++) fifo_q.push_back(16'(i));
    refresh_fifo();
  endtask

  task automatic run_until(input int target, input int budget, input string tag, output int cycles);
    cycles = 0;
    while (n_acc < target && cycles < budget) begin
      step();
      cycles++;
    end
    chk(tag, n_acc, target);
  endtask

  initial begin
    enable  = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    rrst_n  = 1'b0;
    fifo_q.push_back(16'hDEAD);
    refresh_fifo();

    // reset values, then STARTUP blocks the first pop even though the FIFO looks non-empty
    step();
    step();
    chk("rst_fifo_rd", s_rd, 0);
    chk("rst_m_valid", s_vld, 0);
    chk("rst_m_data", s_dat, 0);
    chk("rst_m_last", s_last, 0);
    chk("rst_words", s_wo, 0);
    rrst_n = 1'b1;
    step();
    chk("t1_rd_cycle1", s_rd, 0);
    step();
    chk("t1_rd_cycle2", s_rd, 1);
    step();
    chk("t1_vld_cycle3", s_vld, 1);
    chk("t1_dat_cycle3", s_dat, 16'hDEAD);
    chk("t1_last_cycle3", s_last, 0);

    // streaming at full rate
    do_reset();
    load_words(16);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    run_until(16, 60, "t2_count", cyc);
    chk("t2_cycles", cyc, 18);
    for (int i = 0; i < 16; i++) begin
      chk("t2_data", got_at(i), 16'(i + 1));
      chk("t2_last", last_at(i), (i == 7) || (i == 15));
    end
    step();
    chk("t2_words", s_wo, 16);

    // m_ready toggling every cycle
    do_reset();
    load_words(16);
    rrst_n = 1'b1;
    cyc = 0;
    while (n_acc < 16 && cyc < 80) begin
      m_ready = ~m_ready;
      step();
      cyc++;
    end
    chk("t3_count", n_acc, 16);
    for (int i = 0; i < 16; i++) chk("t3_data", got_at(i), 16'(i + 1));
    chk("t3_last8", last_at(7), 1);
    chk("t3_last16", last_at(15), 1);
    m_ready = 1'b0;
    step();
    chk("t3_words", s_wo, 16);

    // enable dropped mid-packet
    do_reset();
    load_words(16);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    run_until(3, 20, "t4_pre", cyc);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_rd_off", s_rd, 0);
    end
    chk("t4_fifo_left", fifo_q.size(), 12);
    chk("t4_drained", n_acc, 4);
    enable = 1'b1;
    run_until(16, 60, "t4_count", cyc);
    chk("t4_dat8", got_at(7), 16'h0008);
    chk("t4_last7", last_at(6), 0);
    chk("t4_last8", last_at(7), 1);
    chk("t4_last16", last_at(15), 1);

    // flush with two words buffered and beat_cnt=5
    do_reset();
    load_words(20);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    run_until(5, 20, "t5_pre", cyc);
    m_ready = 1'b0;
    step();
    chk("t5_rd_fill", s_rd, 1);
    step();
    chk("t5_rd_occ2", s_rd, 0);
    chk("t5_head", s_dat, 16'h0006);
    flush = 1'b1;
    step();
    chk("t5_rd_flush", s_rd, 0);
    chk("t5_words", s_wo, 5);
    flush = 1'b0;
    step();
    chk("t5_vld_after", s_vld, 0);
    chk("t5_rd_resume", s_rd, 1);
    m_ready = 1'b1;
    run_until(13, 40, "t5_count", cyc);
    chk("t5_first_new", got_at(5), 16'h0008);
    chk("t5_last_early", last_at(11), 0);
    chk("t5_last", last_at(12), 1);
    chk("t5_last_dat", got_at(12), 16'h000F);

    // words_out wraps after 2^16 beats
    do_reset();
    load_words(65537);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    run_until(65537, 65600, "t6_count", cyc);
    m_ready = 1'b0;
    step();
    chk("t6_words_wrap", s_wo, 1);

`ifdef FIFO_READER_STATS_EN
    do_reset();
    rrst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("st_starve", starve_cnt, 4);
    load_words(1);
    for (int i = 0; i < 70000; i++) step();
    chk("st_stall_sat", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_stall_clr", stall_cnt, 0);
    chk("st_starve_clr", starve_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/async_fifo_reader.md
Name: async_fifo_reader

Overview:
- Read-side consumer for the team's dual-clock FIFO; lives entirely in the read clock domain.
- Pops words through the FIFO's rd/rdata/rempty port.
- Holds popped words in a 2-entry skid buffer and emits them as a valid/ready stream, framed into fixed-length packets with m_last.
- Downstream stalls never corrupt or drop data; FIFO backpressure comes from this block simply not popping.

Parameters:
- DW, 16, data width; must match FIFO word width.
- PKT_LEN, 8, beats per packet; legal range 2..65535.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- rclk  in  1  read-domain clock; all logic rising-edge.
- rrst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = allowed to pop FIFO; 0 = stop popping, keep draining buffer.
- flush  in  1  synchronous; discards buffered words and resets packet framing.
- fifo_rempty  in  1  FIFO empty flag (registered in FIFO).
- fifo_rdata  in  DW  FIFO head word; valid whenever fifo_rempty=0.
- fifo_rd  out  1  pop request; pop takes effect at the next rclk edge.
- m_valid  out  1  output beat valid.
- m_data  out  DW  output beat data.
- m_last  out  1  final beat of packet.
- m_ready  in  1  downstream accepts the beat when m_valid & m_ready.
- words_out  out  CNT_W  count of accepted beats; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: fifo_rd=0, m_valid=0, m_data=0, m_last=0, words_out=0, buffer occupancy occ=0, beat_cnt=0, state=STARTUP.
- States:
  - STARTUP: one cycle after rrst_n deasserts. fifo_rd forced 0, because fifo_rempty may read 0 out of reset.
  - Next edge moves to RUN.
  - No other states. Reset from any state returns to STARTUP with the buffer cleared.
- fifo_rd = (state==RUN) & enable & ~flush & ~fifo_rempty & (occ<2). This is combinational from registers and inputs. fifo_rd is never 1 while fifo_rempty=1.
- Capture: on an edge with fifo_rd=1, fifo_rdata is written into the buffer tail.
- Latency: word popped in cycle N appears on m_data with m_valid=1 in cycle N+1 if the buffer was empty.
- Output: m_data/m_valid always show the buffer head; they are registered, with no combinational path from fifo_* to m_*.
- Occupancy update per edge: occ += push − pop.
  - push = fifo_rd.
  - pop = m_valid & m_ready.
  - Simultaneous push and pop at occ=1 keeps occ=1.
  - Sustained throughput is 1 word/cycle with m_ready held high.
- Stall: while m_valid=1 & m_ready=0, m_data/m_last must hold stable. Up to 2 words are held; popping stops at occ=2.
- Framing:
  - beat_cnt (width ceil(log2 PKT_LEN)) increments on each accepted beat.
  - On acceptance with beat_cnt==PKT_LEN−1, beat_cnt wraps to 0.
  - m_last = m_valid & (beat_cnt==PKT_LEN−1).
- words_out increments on each accepted beat and wraps from 2^CNT_W−1 to 0.
- enable=0 mid-packet: no new pops; buffered words still delivered; framing position retained. Resuming continues the same packet.
- flush=1 at an edge:
  - occ→0, m_valid→0, beat_cnt→0.
  - A beat accepted in the same cycle still counts in words_out.
  - fifo_rd is 0 during flush, so no FIFO word is lost.
- FIFO empty mid-packet: m_valid drops after the buffer drains; the packet continues when data returns. No timeout.
- Reset mid-operation: buffered words are discarded; FIFO contents are unaffected by this block.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- Defined: adds output stall_cnt (16 bits) and output starve_cnt (16 bits). Both reset to 0 and saturate at 0xFFFF.
  - stall_cnt increments each cycle with m_valid=1 & m_ready=0.
  - starve_cnt increments each RUN cycle with enable=1, occ=0, fifo_rempty=1.
  - flush clears both.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with fifo_rempty=0, fifo_rdata=0xDEAD -> fifo_rd=0 in the first cycle; a pop occurs in cycle 2; m_valid=1, m_data=0xDEAD in cycle 3.
- FIFO preloaded with 16 words 0x0001..0x0010, m_ready=1, enable=1 -> 16 consecutive beats in order; m_last on 0x0008 and 0x0010; words_out=16.
- Same 16 words, m_ready toggled 1/0 every cycle -> no loss or duplication; m_data stable during stalls; occ never exceeds 2; fifo_rd=0 whenever occ=2.
- Deliver 3 beats, enable=0 for 10 cycles, then enable=1 -> no pops during disable; m_last lands on the 8th accepted beat overall.
- With occ=2 and beat_cnt=5, assert flush for 1 cycle -> m_valid=0 the next cycle; fifo_rd=0 during flush; the next packet's m_last lands on the 8th subsequent beat.
- Accept 65537 beats (CNT_W=16) -> words_out=1; with FIFO_READER_STATS_EN, hold m_ready=0 for 70000 cycles -> stall_cnt=0xFFFF.
